sha256_round_engine: RTL and testbench
======================================

// Module: sha256_round_engine
// PURPOSE
//  Sequential SHA-256 compression engine: accepts an 8-word chaining state and one 16-word message block,
//  runs all 64 rounds with UNROLL rounds per clock and returns the 8-word result over a valid/ready handshake.
//  Generalised successor of the single-round combinational hash step; owns the message schedule, K ROM,
//  round counter and control FSM. Sits between the nonce/block builder and the digest compare stage of the miner.
// PARAMETERS
//  UNROLL      1   rounds computed per clock; legal values 1,2,4,8 (elaboration error otherwise)
//  CNT_W       7   round-counter width; must hold 64 (fixed, not user-overridable)
// PORTS
//  clk            in   1        system clock, all state on rising edge
//  reset_n        in   1        asynchronous, active-low reset
//  flush          in   1        synchronous abort: discard current job
//  in_valid       in   1        state_in/block_in valid
//  in_ready       out  1        engine can accept a job (high only in IDLE)
//  state_in[0:7]  in   32 each  chaining state a..h (IV or midstate)
//  block_in[0:15] in   32 each  message words W0..W15, big-endian word order
//  out_valid      out  1        digest_out valid
//  out_ready      in   1        downstream accepts digest
//  digest_out[0:7] out 32 each  result words H0..H7
//  busy           out  1        high in COMPUTE or DONE
//  round_cnt      out  7        rounds completed in current job (0..64)
// BEHAVIOUR
//  Reset (reset_n=0, any state): FSM->IDLE; in_ready=0 while reset_n low, 1 in the first cycle after release;
//   out_valid=0, busy=0, round_cnt=0, digest_out=0, internal a..h/W/saved-state regs = 0.
//  FSM: IDLE -> COMPUTE on in_valid&&in_ready (accept edge); loads a..h, W window, saved state; round_cnt=0.
//   COMPUTE: each edge performs UNROLL consecutive rounds, round_cnt += UNROLL.
//   COMPUTE -> DONE on the edge where round_cnt reaches 64; digest_out registered on that same edge.
//   DONE: out_valid=1, digest_out held stable until out_valid&&out_ready; then -> IDLE.
//   No job accepted in COMPUTE/DONE (in_ready=0); no skid buffer, no overlap of jobs.
//  Latency: out_valid rises exactly 64/UNROLL+1 edges after the accept edge (65 @UNROLL=1, 17 @UNROLL=4).
//  Throughput: one job per 64/UNROLL+2 cycles with out_ready tied high.
//  Round r (0..63): T1=h+S1(e)+Ch(e,f,g)+K[r]+W[r]; T2=S0(a)+Maj(a,b,c); h..a <= g,f,e,d+T1,c,b,a,T1+T2.
//   S1=ROTR6^ROTR11^ROTR25, S0=ROTR2^ROTR13^ROTR22, Ch=(e&f)^(~e&g), Maj=(a&b)^(a&c)^(b&c).
//  Schedule: 16-word sliding window; W[r] for r>=16 = s1(W[r-2])+W[r-7]+s0(W[r-15])+W[r-16];
//   s0=ROTR7^ROTR18^SHR3, s1=ROTR17^ROTR19^SHR10; window shifts UNROLL words per COMPUTE edge.
//  All additions modulo 2^32 (carry discarded); K is the standard 64-entry FIPS 180-4 table, constant ROM.
//  flush: highest priority after reset; in any state -> IDLE next edge, out_valid=0, round_cnt=0,
//   digest_out keeps last value; in_ready high the cycle after. flush with in_valid in IDLE: job NOT accepted.
//  out_ready asserted outside DONE is ignored. in_valid may drop without accept; inputs sampled only at accept.
//  Inputs state_in/block_in may change freely after the accept edge (fully registered).
// CONFIGURATION
//  SHA256_FEEDFORWARD_EN defined: digest_out[i] = saved state_in[i] + final working reg[i] (standard
//   compression output, chainable as next block's state_in).
//  Not defined: digest_out[i] = final working reg[i] (raw a..h, no feedforward adder; used when the
//   compare stage applies the midstate add itself). Latency/handshake identical in both builds.
// TESTING
//  1 "abc": state_in=FIPS IV (6a09e667..5be0cd19), block_in W0=61626380, W1..W14=0, W15=00000018,
//    FEEDFORWARD_EN -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
//  2 Latency: repeat 1 with UNROLL=1,2,4,8 -> out_valid exactly 65/33/17/9 edges after accept, same digest.
//  3 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and digest_out stable, in_ready=0 throughout;
//    out_ready=1 -> handshake, in_ready=1 next cycle.
//  4 Two-block chain: 56-byte msg "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", feed block-1
//    digest as block-2 state_in -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  5 flush at round_cnt=32 -> IDLE next edge, out_valid never rises; next "abc" job returns test-1 digest.
//  6 reset_n pulsed low mid-COMPUTE -> all outputs 0 immediately (async), in_ready=1 after release.

Source files
------------

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression engine: UNROLL rounds per clock over a 16-word sliding schedule window.
// Define SHA256_FEEDFORWARD_EN to add the saved chaining state into digest_out; otherwise raw a..h is returned.
module sha256_round_engine #(
  parameter  int UNROLL = 1,
  localparam int CNT_W  = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] state_in [0:7],
  input  logic [31:0] block_in [0:15],
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] digest_out [0:7],
  output logic        busy,
  output logic [6:0]  round_cnt
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_round_engine: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] work     [0:7];
  logic [31:0] win      [0:15];
  logic [31:0] nxt_work [0:7];
  logic [31:0] nxt_win  [0:15];
  logic        accept;
  logic        last_step;
`ifdef SHA256_FEEDFORWARD_EN
  logic [31:0] saved    [0:7];
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign accept    = (state == S_IDLE) && in_valid && !flush;
  assign last_step = (round_cnt == CNT_W'(64 - UNROLL));
  assign in_ready  = reset_n && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // The window always holds W[round_cnt .. round_cnt+15], so every W a step needs is already present;
  // the UNROLL words appended at the top may run past W63 on the last step and are simply discarded.
  always_comb begin : datapath
    logic [31:0] ext [0:15+UNROLL];
    logic [31:0] v   [0:7];
    logic [31:0] t1, t2;
    logic [5:0]  kidx;
    t1   = '0;
    t2   = '0;
    kidx = '0;
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    for (int i = 0; i < 8; i++) v[i] = work[i];
    for (int u = 0; u < UNROLL; u++) begin
      kidx = round_cnt[5:0] + 6'(u);
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[kidx] + ext[u];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) nxt_work[i] = v[i];
    for (int i = 0; i < 16; i++) nxt_win[i] = ext[i+UNROLL];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (in_valid)  state_nxt = S_COMPUTE;
        S_COMPUTE: if (last_step) state_nxt = S_DONE;
        S_DONE:    if (out_ready) state_nxt = S_IDLE;
        default:                  state_nxt = S_IDLE;
      endcase
    end
  end

  // Flush only clears the round counter; digest_out deliberately keeps the last completed result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        work[i]       <= '0;
        digest_out[i] <= '0;
`ifdef SHA256_FEEDFORWARD_EN
        saved[i]      <= '0;
`endif
      end
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (flush) begin
      round_cnt <= '0;
    end else if (accept) begin
      round_cnt <= '0;
      work      <= state_in;
      win       <= block_in;
`ifdef SHA256_FEEDFORWARD_EN
      saved     <= state_in;
`endif
    end else if (state == S_COMPUTE) begin
      round_cnt <= round_cnt + CNT_W'(UNROLL);
      work      <= nxt_work;
      win       <= nxt_win;
      if (last_step) begin
        for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FEEDFORWARD_EN
          digest_out[i] <= saved[i] + nxt_work[i];
`else
          digest_out[i] <= nxt_work[i];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: UNROLL=1 and UNROLL=4 instances share stimulus and are checked against
// a plain 64-round reference compression and FIPS known answers (builds with or without SHA256_FEEDFORWARD_EN).
module tb_sha256_round_engine;

`ifdef SHA256_FEEDFORWARD_EN
  localparam bit FEEDFWD = 1'b1;
`else
  localparam bit FEEDFWD = 1'b0;
`endif

  typedef logic [7:0][31:0]  st_t;
  typedef logic [15:0][31:0] blk_t;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] ABC_DIGEST [0:7] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223, 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [31:0] CHAIN_DIGEST [0:7] = '{
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039, 32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [31:0] CHAIN_BLK1 [0:15] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};

  // Latency counted in edges with the accept edge itself as the first one.
  localparam int EXP_LAT1 = 64 / 1 + 1;
  localparam int EXP_LAT4 = 64 / 4 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] state_in [0:7];
  logic [31:0] block_in [0:15];
  logic        in_ready1, out_valid1, busy1, in_ready4, out_valid4, busy4;
  logic [31:0] digest1 [0:7];
  logic [31:0] digest4 [0:7];
  logic [6:0]  round_cnt1, round_cnt4;
  st_t         dig1_p, dig4_p;

  int checks = 0;
  int errors = 0;

  sha256_round_engine #(.UNROLL(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .state_in(state_in), .block_in(block_in), .out_valid(out_valid1), .out_ready(out_ready),
    .digest_out(digest1), .busy(busy1), .round_cnt(round_cnt1));

  sha256_round_engine #(.UNROLL(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .state_in(state_in), .block_in(block_in), .out_valid(out_valid4), .out_ready(out_ready),
    .digest_out(digest4), .busy(busy4), .round_cnt(round_cnt4));

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      dig1_p[i] = digest1[i];
      dig4_p[i] = digest4[i];
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  // Straight textbook compression: full 64-entry schedule, then 64 rounds, returns final a..h.
  function automatic st_t model_raw(input st_t st, input blk_t blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    st_t r;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    a = st[0]; b = st[1]; c = st[2]; d = st[3]; e = st[4]; f = st[5]; g = st[6]; h = st[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f; r[6] = g; r[7] = h;
    return r;
  endfunction

  function automatic st_t model_out(input st_t st, input blk_t blk);
    st_t raw, r;
    raw = model_raw(st, blk);
    for (int i = 0; i < 8; i++) r[i] = FEEDFWD ? st[i] + raw[i] : raw[i];
    return r;
  endfunction

  function automatic st_t iv_state();
    st_t r;
    for (int i = 0; i < 8; i++) r[i] = IV[i];
    return r;
  endfunction

  function automatic blk_t abc_block();
    blk_t r;
    r = '0;
    r[0]  = 32'h61626380;
    r[15] = 32'h00000018;
    return r;
  endfunction

  function automatic st_t abc_expect();
    st_t r;
    for (int i = 0; i < 8; i++) r[i] = FEEDFWD ? ABC_DIGEST[i] : ABC_DIGEST[i] - IV[i];
    return r;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < 8; i++)  state_in[i] = $urandom;
    for (int i = 0; i < 16; i++) block_in[i] = $urandom;
  endtask

  task automatic start_job(input st_t st, input blk_t blk);
    for (int i = 0; i < 8; i++)  state_in[i] = st[i];
    for (int i = 0; i < 16; i++) block_in[i] = blk[i];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Runs one job with out_ready high; reports the edge index (accept edge = 1) at which each out_valid rose.
  task automatic run_job(input st_t st, input blk_t blk, output int lat1, output int lat4,
                         output st_t d1, output st_t d4);
    lat1 = -1; lat4 = -1; d1 = '0; d4 = '0;
    out_ready = 1'b1;
    start_job(st, blk);
    for (int n = 2; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 < 0) begin lat1 = n; d1 = dig1_p; end
      if (out_valid4 && lat4 < 0) begin lat4 = n; d4 = dig4_p; end
      if (lat1 >= 0 && lat4 >= 0) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    scramble_inputs();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready1, out_valid1, busy1, round_cnt1, in_ready4, out_valid4, busy4, round_cnt4} !== 20'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b required all zero",
               {in_ready1, out_valid1, busy1, round_cnt1, in_ready4, out_valid4, busy4, round_cnt4});
    end
    checks++;
    if (dig1_p !== '0 || dig4_p !== '0) begin
      errors++;
      $display("[TB] FAIL reset_digest: got %h / %h required 0", dig1_p, dig4_p);
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b%b required 11", in_ready1, in_ready4);
    end
  endtask

  task automatic test_abc();
    int l1, l4;
    st_t d1, d4, exp;
    exp = abc_expect();
    run_job(iv_state(), abc_block(), l1, l4, d1, d4);
    checks++;
    if (l1 !== EXP_LAT1) begin errors++; $display("[TB] FAIL abc_latency_u1: got %0d required %0d", l1, EXP_LAT1); end
    checks++;
    if (l4 !== EXP_LAT4) begin errors++; $display("[TB] FAIL abc_latency_u4: got %0d required %0d", l4, EXP_LAT4); end
    checks++;
    if (d1 !== exp) begin errors++; $display("[TB] FAIL abc_digest_u1: got %h required %h", d1, exp); end
    checks++;
    if (d4 !== exp) begin errors++; $display("[TB] FAIL abc_digest_u4: got %h required %h", d4, exp); end
    checks++;
    if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abc_back_to_idle: got ready %b%b busy %b%b required ready 11 busy 00",
               in_ready1, in_ready4, busy1, busy4);
    end
  endtask

  task automatic test_backpressure();
    int n;
    st_t snap1, snap4, exp;
    exp = abc_expect();
    out_ready = 1'b0;
    start_job(iv_state(), abc_block());
    n = 1;
    while (!out_valid1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    snap1 = dig1_p;
    snap4 = dig4_p;
    checks++;
    if (n !== EXP_LAT1) begin errors++; $display("[TB] FAIL bp_latency_u1: got %0d required %0d", n, EXP_LAT1); end
    checks++;
    if (snap1 !== exp || snap4 !== exp) begin
      errors++;
      $display("[TB] FAIL bp_digest: got %h / %h required %h", snap1, snap4, exp);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid1 !== 1'b1 || out_valid4 !== 1'b1 || in_ready1 !== 1'b0 || in_ready4 !== 1'b0 ||
          dig1_p !== snap1 || dig4_p !== snap4) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: got valid %b%b ready %b%b required valid 11 ready 00, digest stable",
                 c, out_valid1, out_valid4, in_ready1, in_ready4);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid1 !== 1'b0 || out_valid4 !== 1'b0 || in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid %b%b ready %b%b required valid 00 ready 11",
               out_valid1, out_valid4, in_ready1, in_ready4);
    end
  endtask

  task automatic test_chain();
    int l1, l4;
    st_t d1, d4, exp, st2, raw1;
    blk_t b1, b2;
    for (int i = 0; i < 16; i++) b1[i] = CHAIN_BLK1[i];
    b2 = '0;
    b2[15] = 32'h000001c0;
    exp = model_out(iv_state(), b1);
    run_job(iv_state(), b1, l1, l4, d1, d4);
    checks++;
    if (d1 !== exp || d4 !== exp) begin
      errors++;
      $display("[TB] FAIL chain_block1: got %h / %h required %h", d1, d4, exp);
    end
    raw1 = model_raw(iv_state(), b1);
    for (int i = 0; i < 8; i++) st2[i] = IV[i] + raw1[i];
    for (int i = 0; i < 8; i++) exp[i] = FEEDFWD ? CHAIN_DIGEST[i] : CHAIN_DIGEST[i] - st2[i];
    run_job(st2, b2, l1, l4, d1, d4);
    checks++;
    if (d1 !== exp || d4 !== exp) begin
      errors++;
      $display("[TB] FAIL chain_block2: got %h / %h required %h", d1, d4, exp);
    end
  endtask

  task automatic test_random();
    int l1, l4;
    st_t st, d1, d4, exp;
    blk_t blk;
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 8; i++)  st[i]  = $urandom;
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      exp = model_out(st, blk);
      run_job(st, blk, l1, l4, d1, d4);
      checks++;
      if (d1 !== exp || l1 !== EXP_LAT1) begin
        errors++;
        $display("[TB] FAIL random_u1 job %0d: got %h lat %0d required %h lat %0d", j, d1, l1, exp, EXP_LAT1);
      end
      checks++;
      if (d4 !== exp || l4 !== EXP_LAT4) begin
        errors++;
        $display("[TB] FAIL random_u4 job %0d: got %h lat %0d required %h lat %0d", j, d4, l4, exp, EXP_LAT4);
      end
    end
  endtask

  task automatic test_flush();
    int n;
    bit rose;
    st_t snap1, snap4;
    for (int i = 0; i < 8; i++)  state_in[i] = IV[i];
    for (int i = 0; i < 16; i++) block_in[i] = (i == 0) ? 32'h61626380 : 32'h0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || busy4 !== 1'b0 || in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_blocks_accept: got busy %b%b ready %b%b required busy 00 ready 11",
               busy1, busy4, in_ready1, in_ready4);
    end
    out_ready = 1'b0;
    start_job(iv_state(), abc_block());
    n = 1;
    while (round_cnt1 != 7'd32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (round_cnt1 !== 7'd32 || out_valid4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_setup: got round_cnt %0d valid4 %b required 32 and 1", round_cnt1, out_valid4);
    end
    snap1 = dig1_p;
    snap4 = dig4_p;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({out_valid1, busy1, round_cnt1, out_valid4, busy4, round_cnt4} !== 18'b0 ||
        in_ready1 !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_to_idle: got valid %b%b busy %b%b cnt %0d/%0d ready %b%b required 0s and ready 11",
               out_valid1, out_valid4, busy1, busy4, round_cnt1, round_cnt4, in_ready1, in_ready4);
    end
    checks++;
    if (dig1_p !== snap1 || dig4_p !== snap4) begin
      errors++;
      $display("[TB] FAIL flush_digest_kept: got %h / %h required %h / %h", dig1_p, dig4_p, snap1, snap4);
    end
    rose = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid4 || busy1 || busy4) rose = 1'b1;
    end
    checks++;
    if (rose !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_output: got activity %b required 0", rose); end
    test_abc();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    start_job(iv_state(), abc_block());
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (round_cnt1 !== 7'd10 || round_cnt4 !== 7'd40 || busy1 !== 1'b1 || busy4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL progress: got cnt %0d/%0d busy %b%b required 10/40 busy 11",
               round_cnt1, round_cnt4, busy1, busy4);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready1, out_valid1, busy1, round_cnt1, in_ready4, out_valid4, busy4, round_cnt4} !== 20'b0 ||
        dig1_p !== '0 || dig4_p !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got ctrl %b digest %h / %h required all zero",
               {in_ready1, out_valid1, busy1, round_cnt1, in_ready4, out_valid4, busy4, round_cnt4}, dig1_p, dig4_p);
    end
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready1 !== 1'b1 || in_ready4 !== 1'b1 || busy1 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_release: got ready %b%b busy %b%b required ready 11 busy 00",
               in_ready1, in_ready4, busy1, busy4);
    end
    @(posedge clk); #1;
    test_abc();
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_abc();
    test_backpressure();
    test_chain();
    test_random();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
